// File: rtl/text_pkg.sv
// Shared encodings for the text editing blocks: controller states, command
// priority and the vector storage operations.
package text_pkg;

  typedef enum logic [2:0] {
    READY,
    HANDLE_INPUT,
    HANDLE_INPUT_FINISH,
    ITER,
    ITER_FINISH
  } text_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INSERT,
    CMD_BACKSPACE,
    CMD_DEL,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_HOME,
    CMD_END
  } text_cmd_e;

  typedef enum logic {
    VEC_INSERT,
    VEC_REMOVE
  } vec_op_e;

  function automatic text_cmd_e prio_cmd(input logic sym_nz, input logic backspace,
                                         input logic del, input logic left,
                                         input logic right, input logic home,
                                         input logic end_key);
    if (sym_nz)         return CMD_INSERT;
    else if (backspace) return CMD_BACKSPACE;
    else if (del)       return CMD_DEL;
    else if (left)      return CMD_LEFT;
    else if (right)     return CMD_RIGHT;
    else if (home)      return CMD_HOME;
    else if (end_key)   return CMD_END;
    else                return CMD_NONE;
  endfunction

endpackage

// File: rtl/scrolling_text_buffer_if.sv
// Editing command, iteration and status signals of the scrolling text buffer.
interface scrolling_text_buffer_if #(
  parameter int SYMBOL_WIDTH = 7,
  parameter int LENGTH_WIDTH = 7
);
  logic                    left, right, home, end_key, backspace, del;
  logic [SYMBOL_WIDTH-1:0] symbol;
  logic                    input_ready;
  logic                    full_iter_start, visible_iter_start, iter_en;
  logic [SYMBOL_WIDTH-1:0] iter_out;
  logic                    iter_out_valid, iter_last, cursor_left, cursor_right;
  logic [LENGTH_WIDTH-1:0] length, cursor_index, view_start;

  modport master (
    output left, right, home, end_key, backspace, del, symbol,
    output full_iter_start, visible_iter_start, iter_en,
    input  input_ready, iter_out, iter_out_valid, iter_last,
    input  cursor_left, cursor_right, length, cursor_index, view_start
  );

  modport slave (
    input  left, right, home, end_key, backspace, del, symbol,
    input  full_iter_start, visible_iter_start, iter_en,
    output input_ready, iter_out, iter_out_valid, iter_last,
    output cursor_left, cursor_right, length, cursor_index, view_start
  );
endinterface

// File: rtl/scrolling_text_buffer_vector.sv
// Symbol storage with insert/remove at an index; one operation completes per
// request and is acknowledged by op_ready in the following cycle.
module scrolling_text_buffer_vector
  import text_pkg::*;
#(
  parameter int SYMBOL_WIDTH  = 7,
  parameter int SYMBOLS_COUNT = 127,
  parameter int LENGTH_WIDTH  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  input  vec_op_e                 op_kind,
  input  logic [LENGTH_WIDTH-1:0] op_index,
  input  logic [SYMBOL_WIDTH-1:0] op_symbol,
  output logic                    op_ready,
  input  logic [LENGTH_WIDTH-1:0] rd_index,
  output logic [SYMBOL_WIDTH-1:0] rd_data,
  output logic [LENGTH_WIDTH-1:0] length
);
  localparam logic [LENGTH_WIDTH-1:0] ONE = LENGTH_WIDTH'(1);

  logic [SYMBOL_WIDTH-1:0] mem [SYMBOLS_COUNT];
  logic                    done_q;
  logic [LENGTH_WIDTH-1:0] len_q;
  logic                    start;

  assign start    = op_valid && !done_q;
  assign op_ready = done_q;
  assign length   = len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      len_q  <= '0;
    end else begin
      done_q <= start;
      if (start) len_q <= (op_kind == VEC_INSERT) ? len_q + ONE : len_q - ONE;
    end
  end

  // Contents past len_q are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && start) begin
      if (op_kind == VEC_INSERT) begin
        for (int i = 1; i < SYMBOLS_COUNT; i++)
          if (LENGTH_WIDTH'(i) > op_index) mem[i] <= mem[i-1];
        for (int i = 0; i < SYMBOLS_COUNT; i++)
          if (LENGTH_WIDTH'(i) == op_index) mem[i] <= op_symbol;
      end else begin
        for (int i = 0; i < SYMBOLS_COUNT - 1; i++)
          if (LENGTH_WIDTH'(i) >= op_index) mem[i] <= mem[i+1];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < SYMBOLS_COUNT; i++)
      if (LENGTH_WIDTH'(i) == rd_index && rd_index < len_q) rd_data = mem[i];
  end

endmodule

// File: rtl/scrolling_text_buffer.sv
// Line editor with cursor and scrolling view; emits the whole buffer or the
// visible window one slot per iter_en.
module scrolling_text_buffer
  import text_pkg::*;
#(
  parameter int SYMBOL_WIDTH  = 7,
  parameter int SYMBOLS_COUNT = 127,
  parameter int VISIBLE_COUNT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  scrolling_text_buffer_if.slave  bus
);
  localparam int LENGTH_WIDTH = $clog2(SYMBOLS_COUNT + 1);
  localparam logic [LENGTH_WIDTH-1:0] ONE    = LENGTH_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(SYMBOLS_COUNT);
  localparam logic [LENGTH_WIDTH-1:0] VIS_M1 = LENGTH_WIDTH'(VISIBLE_COUNT - 1);

  text_state_e             state_q, state_d;
  text_cmd_e               cmd_q, cmd_in;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic [LENGTH_WIDTH-1:0] cursor_q, view_q, iter_idx_q, iter_stop_q;
  logic                    view_pending_q;
  logic                    accept_cmd, accept_iter, iter_fire, input_ready;
  logic                    need_op, op_valid, op_ready;
  vec_op_e                 op_kind;
  logic [LENGTH_WIDTH-1:0] op_index, length;
  logic [SYMBOL_WIDTH-1:0] rd_data, iter_out_q;
  logic                    iter_valid_q, iter_last_q, cur_left_q, cur_right_q;

  assign cmd_in = prio_cmd(bus.symbol != '0, bus.backspace, bus.del, bus.left,
                           bus.right, bus.home, bus.end_key);

  always_comb begin
    need_op  = 1'b0;
    op_kind  = VEC_INSERT;
    op_index = cursor_q;
    case (cmd_q)
      CMD_INSERT:    need_op = (length != MAX_LEN);
      CMD_BACKSPACE: begin
        need_op  = (cursor_q != '0);
        op_kind  = VEC_REMOVE;
        op_index = cursor_q - ONE;
      end
      CMD_DEL: begin
        need_op = (cursor_q != length);
        op_kind = VEC_REMOVE;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    accept_cmd  = 1'b0;
    accept_iter = 1'b0;
    iter_fire   = 1'b0;
    op_valid    = 1'b0;
    input_ready = 1'b0;
    case (state_q)
      READY: begin
        if (!view_pending_q) begin
          if (cmd_in != CMD_NONE) begin
            accept_cmd = 1'b1;
            state_d    = HANDLE_INPUT;
          end else if (bus.full_iter_start || bus.visible_iter_start) begin
            accept_iter = 1'b1;
            state_d     = ITER;
          end
        end
      end
      HANDLE_INPUT: begin
        if (need_op) begin
          op_valid = 1'b1;
          if (op_ready) state_d = HANDLE_INPUT_FINISH;
        end else begin
          state_d = HANDLE_INPUT_FINISH;
        end
      end
      HANDLE_INPUT_FINISH: begin
        input_ready = 1'b1;
        state_d     = READY;
      end
      ITER: begin
        if (bus.iter_en) begin
          iter_fire = 1'b1;
          if (iter_idx_q == iter_stop_q) state_d = ITER_FINISH;
        end
      end
      ITER_FINISH: state_d = READY;
      default:     state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= READY;
      cmd_q          <= CMD_NONE;
      sym_q          <= '0;
      cursor_q       <= '0;
      view_q         <= '0;
      iter_idx_q     <= '0;
      iter_stop_q    <= '0;
      view_pending_q <= 1'b0;
      iter_out_q     <= '0;
      iter_valid_q   <= 1'b0;
      iter_last_q    <= 1'b0;
      cur_left_q     <= 1'b0;
      cur_right_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_cmd) begin
        cmd_q <= cmd_in;
        sym_q <= bus.symbol;
      end
      if (accept_iter) begin
        if (bus.full_iter_start) begin
          iter_idx_q  <= '0;
          iter_stop_q <= length;
        end else begin
          iter_idx_q  <= view_q;
          iter_stop_q <= view_q + VIS_M1;
        end
      end
      // Length is already post-operation here, so saturation uses the new value.
      if (state_q == HANDLE_INPUT_FINISH) begin
        view_pending_q <= 1'b1;
        case (cmd_q)
          CMD_INSERT, CMD_RIGHT:   if (cursor_q < length) cursor_q <= cursor_q + ONE;
          CMD_BACKSPACE, CMD_LEFT: if (cursor_q != '0) cursor_q <= cursor_q - ONE;
          CMD_HOME:                cursor_q <= '0;
          CMD_END:                 cursor_q <= length;
          default: ;
        endcase
      end else if (view_pending_q) begin
        view_pending_q <= 1'b0;
        if (cursor_q < view_q)               view_q <= cursor_q;
        else if (cursor_q > view_q + VIS_M1) view_q <= cursor_q - VIS_M1;
      end
      iter_valid_q <= iter_fire;
      iter_out_q   <= iter_fire ? rd_data : '0;
      iter_last_q  <= iter_fire && (iter_idx_q == iter_stop_q);
      cur_left_q   <= iter_fire && (iter_idx_q == cursor_q);
      cur_right_q  <= iter_fire && (cursor_q != '0) && (iter_idx_q == cursor_q - ONE);
      if (iter_fire) iter_idx_q <= iter_idx_q + ONE;
    end
  end

  scrolling_text_buffer_vector #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .SYMBOLS_COUNT(SYMBOLS_COUNT),
    .LENGTH_WIDTH (LENGTH_WIDTH)
  ) u_vector (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_kind  (op_kind),
    .op_index (op_index),
    .op_symbol(sym_q),
    .op_ready (op_ready),
    .rd_index (iter_idx_q),
    .rd_data  (rd_data),
    .length   (length)
  );

  assign bus.input_ready    = input_ready;
  assign bus.iter_out       = iter_out_q;
  assign bus.iter_out_valid = iter_valid_q;
  assign bus.iter_last      = iter_last_q;
  assign bus.cursor_left    = cur_left_q;
  assign bus.cursor_right   = cur_right_q;
  assign bus.length         = length;
  assign bus.cursor_index   = cursor_q;
  assign bus.view_start     = view_q;

endmodule
